// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - memory-mapped timer and external interrupt source
// Drives the core's 2-bit interrupt input: [0] machine timer compare, [1] external line.
module interrupt_controller #(
   parameter int          PRESC_W   = 16,
   parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic [3:0]  mask,
   input  logic        ext_irq,
   output logic [31:0] read_data,
   output logic [1:0]  interrupt
);

   localparam logic [2:0] A_MTIME_LO = 3'd0;
   localparam logic [2:0] A_MTIME_HI = 3'd1;
   localparam logic [2:0] A_CMP_LO   = 3'd2;
   localparam logic [2:0] A_CMP_HI   = 3'd3;
   localparam logic [2:0] A_IE       = 3'd4;
   localparam logic [2:0] A_IP       = 3'd5;
   localparam logic [2:0] A_PRESC    = 3'd6;
   localparam logic [PRESC_W-1:0] PC_ONE = PRESC_W'(1);

   logic [63:0]        mtime_q, mtime_d;
   logic [63:0]        cmp_q, cmp_d;
   logic [PRESC_W-1:0] pc_q, pc_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [1:0]         ie_q, ie_d;
   logic               ext_ip_q, ext_ip_d;
   logic               s1_q, s2_q, s3_q;
   logic [1:0]         irq_q, irq_d;

   logic        wr;
   logic [2:0]  sel;
   logic        tick;
   logic        tmr_ip;
   logic        ext_set;
   logic        ext_clr;
   logic [31:0] reg_val;
   logic [31:0] byte_mask;
   logic [31:0] wval;
   logic        unused_addr;

   assign wr          = cs & wr_en;
   assign sel         = addr[4:2];
   assign unused_addr = ^{addr[31:5], addr[1:0]};
   assign tick        = (pc_q == presc_q);
   assign tmr_ip      = (mtime_q >= cmp_q);
   assign ext_set     = s2_q & ~s3_q;
   assign ext_clr     = wr & (sel == A_IP) & mask[0] & write_data[1];

   always_comb begin
      reg_val = 32'h0;
      case (sel)
         A_MTIME_LO: reg_val = mtime_q[31:0];
         A_MTIME_HI: reg_val = mtime_q[63:32];
         A_CMP_LO:   reg_val = cmp_q[31:0];
         A_CMP_HI:   reg_val = cmp_q[63:32];
         A_IE:       reg_val = {30'h0, ie_q};
         A_IP:       reg_val = {30'h0, ext_ip_q, tmr_ip};
         A_PRESC:    reg_val = 32'(presc_q);
         default:    reg_val = 32'h0;
      endcase
   end

   assign read_data = (cs & rd_en) ? reg_val : 32'h0;

   // Byte-enable merge of the store into the currently selected register.
   assign byte_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
   assign wval      = (reg_val & ~byte_mask) | (write_data & byte_mask);

   always_comb begin
      mtime_d  = mtime_q;
      cmp_d    = cmp_q;
      ie_d     = ie_q;
      presc_d  = presc_q;
      pc_d     = tick ? '0 : pc_q + PC_ONE;
      ext_ip_d = ext_set | (ext_ip_q & ~ext_clr);
      irq_d    = {ext_ip_q & ie_q[1], tmr_ip & ie_q[0]};

      // A software write to either MTIME half suppresses that cycle's increment.
      if (wr && sel == A_MTIME_LO) begin
         mtime_d[31:0] = wval;
      end else if (wr && sel == A_MTIME_HI) begin
         mtime_d[63:32] = wval;
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end

      if (wr) begin
         case (sel)
            A_CMP_LO: cmp_d[31:0]  = wval;
            A_CMP_HI: cmp_d[63:32] = wval;
            A_IE:     ie_d         = wval[1:0];
            A_PRESC: begin
               presc_d = wval[PRESC_W-1:0];
               pc_d    = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mtime_q  <= 64'h0;
         cmp_q    <= CMP_RESET;
         pc_q     <= '0;
         presc_q  <= '0;
         ie_q     <= 2'b00;
         ext_ip_q <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         irq_q    <= 2'b00;
      end else begin
         mtime_q  <= mtime_d;
         cmp_q    <= cmp_d;
         pc_q     <= pc_d;
         presc_q  <= presc_d;
         ie_q     <= ie_d;
         ext_ip_q <= ext_ip_d;
         s1_q     <= ext_irq;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         irq_q    <= irq_d;
      end
   end

   assign interrupt = irq_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - randomized bench against a register-level reference model
module tb_interrupt_controller;

   logic        clk = 1'b0;
   logic        reset, cs, rd_en, wr_en, ext_irq;
   logic [31:0] addr, write_data, read_data;
   logic [3:0]  mask;
   logic [1:0]  interrupt;

   always #5 clk = ~clk;

   interrupt_controller dut (
      .clk(clk), .reset(reset), .cs(cs), .rd_en(rd_en), .wr_en(wr_en),
      .addr(addr), .write_data(write_data), .mask(mask), .ext_irq(ext_irq),
      .read_data(read_data), .interrupt(interrupt)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference state: the architectural registers plus a history of sampled ext_irq values.
   logic [63:0] m_mtime, m_cmp;
   logic [15:0] m_pc, m_presc;
   logic [1:0]  m_ie, m_irq;
   logic        m_ip1;
   logic [2:0]  m_hist;

   function automatic logic [31:0] m_reg(input logic [2:0] a);
      case (a)
         3'd0: return m_mtime[31:0];
         3'd1: return m_mtime[63:32];
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return {30'h0, m_ie};
         3'd5: return {30'h0, m_ip1, m_mtime >= m_cmp};
         3'd6: return {16'h0, m_presc};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++)
         if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   logic [1:0]  n_irq;
   logic        n_set, n_tick, n_wr;
   logic [2:0]  n_a;
   logic [31:0] n_val;

   always @(posedge clk) begin
      if (reset) begin
         m_mtime = 64'h0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
         m_pc = 16'h0; m_presc = 16'h0; m_ie = 2'b00; m_ip1 = 1'b0;
         m_hist = 3'b000; m_irq = 2'b00;
      end else begin
         n_irq  = {m_ip1 & m_ie[1], (m_mtime >= m_cmp) & m_ie[0]};
         // ext sampled two edges ago high, three edges ago low
         n_set  = m_hist[1] & ~m_hist[2];
         n_tick = (m_pc == m_presc);
         n_wr   = cs & wr_en;
         n_a    = addr[4:2];
         n_val  = merge(m_reg(n_a), write_data, mask);
         m_pc   = n_tick ? 16'h0 : m_pc + 16'h1;
         if (n_wr && n_a == 3'd0)      m_mtime[31:0]  = n_val;
         else if (n_wr && n_a == 3'd1) m_mtime[63:32] = n_val;
         else if (n_tick)              m_mtime        = m_mtime + 64'h1;
         if (n_wr && n_a == 3'd2) m_cmp[31:0]  = n_val;
         if (n_wr && n_a == 3'd3) m_cmp[63:32] = n_val;
         if (n_wr && n_a == 3'd4) m_ie = n_val[1:0];
         if (n_wr && n_a == 3'd6) begin m_presc = n_val[15:0]; m_pc = 16'h0; end
         if (n_wr && n_a == 3'd5 && mask[0] && write_data[1]) m_ip1 = 1'b0;
         if (n_set) m_ip1 = 1'b1;
         m_hist = {m_hist[1:0], ext_irq};
         m_irq  = n_irq;
      end
   end

   logic [31:0] last_rd;
   logic [1:0]  last_irq;
   logic        ext_cur = 1'b0;

   task automatic cyc(input logic r, input logic c, input logic rd, input logic wr,
                      input logic [2:0] a, input logic [31:0] wd, input logic [3:0] m, input logic e);
      logic [31:0] up;
      up = $urandom;
      reset = r; cs = c; rd_en = rd; wr_en = wr;
      addr = {up[31:5], a, up[1:0]}; write_data = wd; mask = m; ext_irq = e;
      #1;
      last_rd  = read_data;
      last_irq = interrupt;
      check("irq", interrupt, m_irq);
      check($sformatf("rdata[%0d]", a), read_data, (c && rd) ? m_reg(a) : 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, ext_cur);
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] v, input logic [3:0] m);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, a, v, m, ext_cur);
   endtask

   task automatic rd_exp(input string tag, input logic [2:0] a, input logic [31:0] exp);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0, ext_cur);
      check(tag, last_rd, exp);
   endtask

   task automatic reset_reads();
      rd_exp("rst_mtime_lo", 3'd0, 32'h0);
      rd_exp("rst_mtime_hi", 3'd1, 32'h0);
      rd_exp("rst_cmp_lo",   3'd2, 32'hFFFF_FFFF);
      rd_exp("rst_cmp_hi",   3'd3, 32'hFFFF_FFFF);
      rd_exp("rst_ie",       3'd4, 32'h0);
      rd_exp("rst_ip",       3'd5, 32'h0);
      rd_exp("rst_presc",    3'd6, 32'h0);
      rd_exp("rst_off7",     3'd7, 32'h0);
   endtask

   initial begin
      reset = 1'b1; cs = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 32'h0;
      write_data = 32'h0; mask = 4'h0; ext_irq = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_reads();
      check("rst_irq", last_irq, 2'b00);

      // Prescaled timer compare
      wr_reg(3'd6, 32'd3, 4'hF);
      wr_reg(3'd0, 32'd0, 4'hF);
      wr_reg(3'd1, 32'd0, 4'hF);
      wr_reg(3'd3, 32'd0, 4'hF);
      wr_reg(3'd2, 32'd5, 4'hF);
      wr_reg(3'd4, 32'd1, 4'hF);
      idle(30);
      check("tmr_irq_on", last_irq, 2'b01);
      wr_reg(3'd2, 32'd100, 4'hF);
      idle(2);
      check("tmr_irq_off", last_irq, 2'b00);

      // Carry into MTIME_HI, write-over-increment, 64-bit wrap
      wr_reg(3'd6, 32'd0, 4'hF);
      wr_reg(3'd1, 32'd0, 4'hF);
      wr_reg(3'd0, 32'hFFFF_FFFF, 4'hF);
      idle(1);
      rd_exp("carry_hi", 3'd1, 32'd1);
      wr_reg(3'd0, 32'h1234, 4'hF);
      rd_exp("wr_over_inc", 3'd0, 32'h1234);
      wr_reg(3'd1, 32'hFFFF_FFFF, 4'hF);
      wr_reg(3'd0, 32'hFFFF_FFFC, 4'hF);
      idle(8);
      rd_exp("wrap_hi", 3'd1, 32'h0);

      // Byte-masked write
      wr_reg(3'd2, 32'hFFFF_FFFF, 4'hF);
      wr_reg(3'd2, 32'h0000_AB00, 4'b0010);
      rd_exp("mask_wr", 3'd2, 32'hFFFF_ABFF);

      // External interrupt: latency, W1C, held level, set-beats-clear
      wr_reg(3'd3, 32'hFFFF_FFFF, 4'hF);
      wr_reg(3'd4, 32'd2, 4'hF);
      idle(3);
      ext_cur = 1'b1;
      idle(6);
      rd_exp("ext_pend", 3'd5, 32'd2);
      check("ext_irq_on", last_irq, 2'b10);
      wr_reg(3'd5, 32'd2, 4'hF);
      idle(5);
      rd_exp("ext_held", 3'd5, 32'd0);
      check("ext_held_irq", last_irq, 2'b00);
      ext_cur = 1'b0;
      idle(4);
      ext_cur = 1'b1;
      idle(4);
      ext_cur = 1'b0;
      idle(3);
      ext_cur = 1'b1;
      idle(2);
      wr_reg(3'd5, 32'd2, 4'hF);
      rd_exp("set_wins", 3'd5, 32'd2);
      idle(1);
      check("set_wins_irq", last_irq, 2'b10);

      // Reset with both sources asserted
      wr_reg(3'd4, 32'd3, 4'hF);
      wr_reg(3'd3, 32'd0, 4'hF);
      wr_reg(3'd2, 32'd0, 4'hF);
      ext_cur = 1'b0;
      idle(3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
      check("pre_rst_irq", last_irq, 2'b11);
      reset_reads();
      check("post_rst_irq", last_irq, 2'b00);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic        r, c, rd, w;
         logic [2:0]  a;
         logic [31:0] wd, rnd;
         logic [3:0]  m;
         rnd = $urandom;
         r   = ($urandom_range(0, 299) == 0);
         c   = (rnd[1:0] != 2'b00);
         rd  = rnd[2];
         w   = rnd[3];
         a   = rnd[6:4];
         m   = rnd[7] ? 4'hF : rnd[11:8];
         if (a == 3'd6)       wd = $urandom_range(0, 5);
         else if (rnd[12])    wd = $urandom_range(0, 64);
         else                 wd = $urandom;
         if ($urandom_range(0, 5) == 0) ext_cur = ~ext_cur;
         cyc(r, c, rd, w, a, wd, m, ext_cur);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Memory-mapped interrupt source that drives the core's 2-bit `interrupt` input. It holds a 64-bit prescaled machine timer with compare register, and an external interrupt line with synchronizer, edge detect and pending latch. Per-source enables gate both sources, and the result is registered onto `interrupt[1:0]`. It sits on the data-memory port beside `data_memory`: the core programs and acknowledges it with ordinary loads and stores, selected by `cs`.

## Interface
Parameters:
- PRESC_W, 16, width of prescaler reload register and counter
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of MTIMECMP

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- cs  in  1  block select from address decode
- rd_en  in  1  read strobe, qualified by cs
- wr_en  in  1  write strobe, qualified by cs
- addr  in  32  byte address; only addr[4:2] decoded
- write_data  in  32  store data
- mask  in  4  byte enables for writes, bit n enables write_data[8n+7:8n]
- ext_irq  in  1  asynchronous external interrupt request, active-high
- read_data  out  32  combinational read data
- interrupt  out  2  registered request to core: [0] timer, [1] external

## Operation
Register map, selected by addr[4:2]:
- 0 MTIME_LO, RW
- 1 MTIME_HI, RW
- 2 MTIMECMP_LO, RW
- 3 MTIMECMP_HI, RW
- 4 IE, RW, bits[1:0]
- 5 IP, R, bits[1:0]. Writing 1 to bit1 clears the external pending bit. Bit0 is read-only.
- 6 PRESCALE, RW, bits[PRESC_W-1:0]
- 7 reads 0, writes ignored

Register access:
- Write occurs when cs & wr_en at the clock edge. Only bytes enabled by mask are updated, and bits beyond a register's width are ignored.
- read_data = selected register when cs & rd_en, else 32'h0. Unused bits read 0.

Timer:
- Prescale counter pc counts 0..PRESCALE. When pc == PRESCALE, pc returns to 0 and MTIME increments by 1 as a single 64-bit quantity, with carry from LO into HI. PRESCALE = 0 means MTIME increments every cycle.
- A write to MTIME_LO or MTIME_HI in a cycle takes priority over the increment. The written half takes the write value, the other half holds, and no increment occurs that cycle.
- A write to PRESCALE resets pc to 0.
- Timer pending ip[0] = (MTIME >= MTIMECMP), 64-bit unsigned, evaluated on current register values. Software clears it only by raising MTIMECMP or lowering MTIME.

External interrupt:
- ext_irq passes through a 2-flop synchronizer (s1, s2) and an edge register s3.
- A rising edge is s2 & ~s3. It sets ip[1].
- A W1C write to IP bit1 clears ip[1]. If a set and a clear occur in the same cycle, set wins.

Output:
- interrupt[i] <= ip[i] & ie[i], registered each cycle.

Reset values (all outputs included):
- MTIME = 0, pc = 0, MTIMECMP = CMP_RESET, IE = 0, ip[1] = 0, PRESCALE = 0
- s1, s2, s3 = 0, interrupt = 2'b00
- read_data is combinational and therefore 0 when not selected

## Timing
- Read: zero latency. read_data is valid in the same cycle as cs & rd_en & addr.
- Write: visible to a read in the cycle after the write edge.
- Timer interrupt: MTIME reaches MTIMECMP at edge N, so ip[0] is true after edge N, and interrupt[0] = 1 after edge N+1 if ie[0] = 1.
- External interrupt: ext_irq rises before edge N. s1 is set at N, s2 at N+1, ip[1] at N+2, interrupt[1] at N+3.
- Enable change: a write to IE at edge N changes interrupt at edge N+1.
- Acknowledge: a W1C to IP at edge N drops interrupt[1] at edge N+1, unless a new edge set ip[1] in the same cycle.
- Wrap-around: MTIME = 64'hFFFF_FFFF_FFFF_FFFF increments to 0. Pending is then re-evaluated, so ip[0] falls unless MTIMECMP == 0.
- Reset asserted mid-count or mid-pending: all state returns to reset values at that edge, and interrupt = 0 from the next cycle.
- A held-high ext_irq produces exactly one set. A new set requires a low then high transition.

## Test plan
- Reset, then read offsets 0–7 → read 0,0,FFFFFFFF,FFFFFFFF,0,0,0,0; interrupt = 00.
- PRESCALE = 3, MTIME = 0, MTIMECMP = 5, IE = 01 → MTIME steps every 4 cycles. interrupt[0] rises 1 cycle after MTIME reads 5. Writing MTIMECMP_LO = 100 drops interrupt[0] on the next edge.
- MTIME_LO = FFFFFFFF, MTIME_HI = 0, PRESCALE = 0 → one cycle later HI = 1, LO = 0. A write to MTIME_LO in the same cycle as an increment leaves exactly the written value.
- IE = 10, ext_irq 0→1 and held → interrupt[1] = 1 exactly 3 edges after the pulse is sampled. W1C IP = 2 clears it, and it stays 0 while ext_irq remains high.
- W1C of IP bit1 coincident with a new synchronized rising edge → ip[1] remains 1 and interrupt[1] remains 1.
- Byte-masked write mask = 0010, write_data = 0000AB00 to MTIMECMP_LO from FFFFFFFF → reads FFFFABFF. Reset asserted while interrupt = 11 → interrupt = 00 next cycle, all registers at reset values.
